// File: rtl/stall_fwd_unit.sv
// Hazard unit for a 5-stage pipeline: tracks E/M/W producer records, raises a
// load/use-style stall from Tuse vs Tnew and picks the youngest bypass source.
module stall_fwd_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic       d_b_type,
  input  logic       d_cal_i,
  input  logic       d_cal_r,
  input  logic       d_load,
  input  logic       d_store,
  input  logic       d_jr,
  input  logic       d_jal,
  input  logic       d_ji,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [1:0] fwd_rt_m
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
  } rec_t;

  rec_t       d_rec, e_q, m_q, w_q;
  logic       rs_used, rt_used;
  logic [1:0] tuse_rs, tuse_rt;

  always_comb begin
    d_rec       = '0;
    d_rec.valid = d_valid;
    d_rec.rs    = d_rs;
    d_rec.rt    = d_rt;
    if (d_cal_r)                d_rec.dst = d_rd;
    else if (d_cal_i || d_load) d_rec.dst = d_rt;
    else if (d_jal)             d_rec.dst = 5'd31;
    if (d_load)                 d_rec.tnew = 2'd2;
    else if (d_cal_r || d_cal_i) d_rec.tnew = 2'd1;
  end

  // Branches/jumps resolve in D, so their sources are needed immediately.
  always_comb begin
    rs_used = d_b_type | d_jr | d_cal_r | d_cal_i | d_load | d_store;
    tuse_rs = (d_b_type | d_jr) ? 2'd0 : 2'd1;
    rt_used = d_b_type | d_ji | d_cal_r | d_store;
    tuse_rt = (d_b_type | d_ji) ? 2'd0 : (d_cal_r ? 2'd1 : 2'd2);
  end

  function automatic logic hit(rec_t p, logic [4:0] src);
    return p.valid && (p.dst != 5'd0) && (p.dst == src);
  endfunction

  function automatic logic hazard(rec_t p, logic used, logic [4:0] src, logic [1:0] tuse);
    return used && hit(p, src) && (tuse < p.tnew);
  endfunction

  // Youngest match wins; if it is not ready yet the stall covers it, so select 0.
  function automatic logic [1:0] fwd_sel(logic [4:0] src, rec_t e, rec_t m, rec_t w);
    if (hit(e, src)) return (e.tnew == 2'd0) ? 2'd3 : 2'd0;
    if (hit(m, src)) return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    if (hit(w, src)) return (w.tnew == 2'd0) ? 2'd1 : 2'd0;
    return 2'd0;
  endfunction

  always_comb begin
    stall = d_valid && (hazard(e_q, rs_used, d_rs, tuse_rs) || hazard(e_q, rt_used, d_rt, tuse_rt) ||
                        hazard(m_q, rs_used, d_rs, tuse_rs) || hazard(m_q, rt_used, d_rt, tuse_rt));
    fwd_rs_d = d_valid ? fwd_sel(d_rs, e_q, m_q, w_q) : 2'd0;
    fwd_rt_d = d_valid ? fwd_sel(d_rt, e_q, m_q, w_q) : 2'd0;
    fwd_rs_e = fwd_sel(e_q.rs, '0, m_q, w_q);
    fwd_rt_e = fwd_sel(e_q.rt, '0, m_q, w_q);
    fwd_rt_m = fwd_sel(m_q.rt, '0, '0, w_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q      <= stall ? '0 : d_rec;
      m_q      <= e_q;
      m_q.tnew <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      w_q      <= m_q;
      w_q.tnew <= 2'd0;
    end
  end

endmodule

// File: tb/tb_stall_fwd_unit.sv
// Bench for stall_fwd_unit: directed pipeline scenarios with literal
// expectations plus random instruction streams against a stage-list model.
module tb_stall_fwd_unit;
  localparam int NOP = 0, BR = 1, CALI = 2, CALR = 3, LOAD = 4, STORE = 5, JR = 6, JAL = 7, JI = 8;

  logic       clk = 0, reset;
  logic       d_valid, d_b_type, d_cal_i, d_cal_r, d_load, d_store, d_jr, d_jal, d_ji;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  stall_fwd_unit dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_b_type(d_b_type), .d_cal_i(d_cal_i),
    .d_cal_r(d_cal_r), .d_load(d_load), .d_store(d_store), .d_jr(d_jr), .d_jal(d_jal),
    .d_ji(d_ji), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_on = 0;
  int cur_cls = NOP, cur_v = 0, cur_rs = 0, cur_rt = 0, cur_rd = 0;

  // Model: index 0 = E, 1 = M, 2 = W.
  typedef struct { bit v; int rs, rt, dst, tnew; } mrec_t;
  mrec_t mdl[3];

  function automatic mrec_t mk(bit v, int rs, int rt, int dst, int tnew);
    mrec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.dst = dst; r.tnew = tnew;
    return r;
  endfunction

  function automatic int dst_of(int c);
    if (c == CALR) return cur_rd;
    if (c == CALI || c == LOAD) return cur_rt;
    if (c == JAL) return 31;
    return 0;
  endfunction

  function automatic int tnew_of(int c);
    if (c == LOAD) return 2;
    if (c == CALI || c == CALR) return 1;
    return 0;
  endfunction

  // -1 means the field is not read.
  function automatic int tuse_rs_of(int c);
    if (c == BR || c == JR) return 0;
    if (c == CALR || c == CALI || c == LOAD || c == STORE) return 1;
    return -1;
  endfunction

  function automatic int tuse_rt_of(int c);
    if (c == BR || c == JI) return 0;
    if (c == CALR) return 1;
    if (c == STORE) return 2;
    return -1;
  endfunction

  function automatic bit model_stall();
    int tr = tuse_rs_of(cur_cls), tt = tuse_rt_of(cur_cls);
    if (cur_v == 0) return 0;
    for (int s = 0; s < 2; s++) begin
      if (mdl[s].v && mdl[s].dst != 0) begin
        if (tr >= 0 && cur_rs == mdl[s].dst && tr < mdl[s].tnew) return 1;
        if (tt >= 0 && cur_rt == mdl[s].dst && tt < mdl[s].tnew) return 1;
      end
    end
    return 0;
  endfunction

  function automatic int msel(int src, int first);
    for (int s = first; s < 3; s++)
      if (mdl[s].v && mdl[s].dst != 0 && mdl[s].dst == src)
        return (mdl[s].tnew == 0) ? 3 - s : 0;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) mdl[s] <= mk(0, 0, 0, 0, 0);
    end else begin
      mdl[2] <= mk(mdl[1].v, mdl[1].rs, mdl[1].rt, mdl[1].dst, 0);
      mdl[1] <= mk(mdl[0].v, mdl[0].rs, mdl[0].rt, mdl[0].dst, (mdl[0].tnew > 0) ? mdl[0].tnew - 1 : 0);
      if (model_stall()) mdl[0] <= mk(0, 0, 0, 0, 0);
      else mdl[0] <= mk(cur_v != 0, cur_rs, cur_rt, dst_of(cur_cls), tnew_of(cur_cls));
    end
  end

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_stall",    int'(stall),    int'(model_stall()));
      chk("m_fwd_rs_d", int'(fwd_rs_d), cur_v != 0 ? msel(cur_rs, 0) : 0);
      chk("m_fwd_rt_d", int'(fwd_rt_d), cur_v != 0 ? msel(cur_rt, 0) : 0);
      chk("m_fwd_rs_e", int'(fwd_rs_e), msel(mdl[0].rs, 1));
      chk("m_fwd_rt_e", int'(fwd_rt_e), msel(mdl[0].rt, 1));
      chk("m_fwd_rt_m", int'(fwd_rt_m), msel(mdl[1].rt, 2));
    end
  end

  task automatic ins(int c, int rs, int rt, int rd, int v = 1);
    cur_cls = c; cur_v = v; cur_rs = rs; cur_rt = rt; cur_rd = rd;
    d_valid = (v != 0); d_b_type = (c == BR); d_cal_i = (c == CALI); d_cal_r = (c == CALR);
    d_load = (c == LOAD); d_store = (c == STORE); d_jr = (c == JR); d_jal = (c == JAL);
    d_ji = (c == JI);
    d_rs = rs[4:0]; d_rt = rt[4:0]; d_rd = rd[4:0];
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    ins(NOP, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic all_zero(string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_sel"}, int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
  endtask

  function automatic int rreg();
    int r = $urandom_range(0, 8);
    return (r == 8) ? 31 : r;
  endfunction

  initial begin
    reset = 1;
    ins(NOP, 0, 0, 0, 0);
    tick();
    tick();
    chk_on = 1;
    reset = 0;
    all_zero("reset");

    // lw $5 ; addu $6,$5,$7
    ins(LOAD, 1, 5, 0);        chk("lw_use_pre", int'(stall), 0);
    tick(); ins(CALR, 5, 7, 6); chk("lw_use_stall", int'(stall), 1);
    tick();                    chk("lw_use_release", int'(stall), 0);
    chk("lw_use_d_notready", int'(fwd_rs_d), 0);
    tick(); ins(NOP, 0, 0, 0, 0);
    chk("lw_use_fwd_e_w", int'(fwd_rs_e), 1);
    flush();

    // addu $3,$1,$2 ; beq $3,$0
    ins(CALR, 1, 2, 3);
    tick(); ins(BR, 3, 0, 0);  chk("br_stall", int'(stall), 1);
    tick();                    chk("br_release", int'(stall), 0);
    chk("br_fwd_d_m", int'(fwd_rs_d), 2);
    chk("br_rt_zero", int'(fwd_rt_d), 0);
    flush();

    // jal ; jr $31
    ins(JAL, 0, 0, 0);
    tick(); ins(JR, 31, 0, 0); chk("jr_stall", int'(stall), 0);
    chk("jr_fwd_d_e", int'(fwd_rs_d), 3);
    flush();

    // ori $4,$0,1 ; sw $4,0($9)
    ins(CALI, 0, 4, 0);
    tick(); ins(STORE, 9, 4, 0); chk("sw_stall", int'(stall), 0);
    tick(); ins(NOP, 0, 0, 0, 0); chk("sw_fwd_e_m", int'(fwd_rt_e), 2);
    tick();                      chk("sw_fwd_m_w", int'(fwd_rt_m), 1);
    flush();

    // $0 never forwards or stalls; invalid D never stalls
    ins(LOAD, 0, 0, 0);
    tick(); ins(CALR, 0, 0, 1); all_zero("zero_reg");
    flush();
    ins(LOAD, 0, 5, 0);
    tick(); ins(CALR, 5, 5, 1, 0);
    chk("inv_stall", int'(stall), 0);
    chk("inv_fwd", int'({fwd_rs_d, fwd_rt_d}), 0);
    flush();

    // reset in mid-stall
    ins(LOAD, 0, 5, 0);
    tick(); ins(CALR, 5, 7, 6); chk("rst_pre_stall", int'(stall), 1);
    reset = 1;
    tick(); reset = 0;
    #1 all_zero("rst_abort");
    flush();

    // random streams
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      ins($urandom_range(0, 8), rreg(), rreg(), rreg(), ($urandom_range(0, 4) != 0) ? 1 : 0);
      tick();
    end
    reset = 0;
    chk_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
